main_control: RTL
=================

MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 SHALL be clocked on a single clock; reset is synchronous and active-high.
REQ-002 clock  in  1  system clock, rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register.
REQ-005 zero  in  1  ALU zero flag, valid in BRANCH state.
REQ-006 pc_en  out  1  PC load enable.
REQ-007 iord  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-008 mem_read  out  1  memory read strobe.
REQ-009 mem_write  out  1  memory write strobe.
REQ-010 ir_write  out  1  instruction register load.
REQ-011 reg_dst  out  1  write register: 0 rt, 1 rd.
REQ-012 mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR.
REQ-013 reg_write  out  1  register file write enable.
REQ-014 alu_src_a  out  1  ALU A: 0 PC, 1 reg A.
REQ-015 alu_src_b  out  2  ALU B: 00 reg B, 01 const 4, 10 ext imm, 11 sign-ext imm<<2.
REQ-016 ext_zero  out  1  immediate extension: 1 zero-extend, 0 sign-extend.
REQ-017 pc_source  out  2  PC input: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-018 alu_op  out  4  operation class to the ALU control stage.
REQ-019 illegal  out  1  one-cycle pulse on undefined opcode.

Function
REQ-020 SHALL be a Moore FSM; all outputs decode from the state register only, except pc_en in BRANCH.
REQ-021 alu_op encoding SHALL be: 0000 add, 0001 sub, 0010 R-type (funct decides), 0011 and, 0101 or, 0110 slt, 0100 lui shift.
REQ-022 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-023 FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_source=00, pc_en=1; next DECODE.
REQ-024 DECODE: alu_src_a=0, alu_src_b=11, alu_op=0000; next is selected by opcode.
REQ-025 Opcode dispatch: 000000 -> R_EXEC; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010 -> JUMP; 001000/001100/001101/001010/001111 -> I_EXEC.
REQ-026 Any other opcode in DECODE SHALL pulse illegal=1 for one cycle and return to FETCH with no register or memory write.
REQ-027 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0000; next MEM_RD for 100011, MEM_WR for 101011.
REQ-028 MEM_RD: mem_read=1, iord=1; next MEM_WB.
REQ-029 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-030 MEM_WR: mem_write=1, iord=1; next FETCH.
REQ-031 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=0010; next R_WB.
REQ-032 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-033 I_EXEC: alu_src_a=1, alu_src_b=10.
  - alu_op by opcode: addi 0000, andi 0011, ori 0101, slti 0110, lui 0100.
  - ext_zero=1 for andi/ori/lui, 0 otherwise.
  - next I_WB.
REQ-034 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-035 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001, pc_source=01; next FETCH.
  - pc_en = zero for beq.
  - pc_en = ~zero for bne.
REQ-036 JUMP: pc_source=10, pc_en=1; next FETCH.
REQ-037 Outputs not listed for a state SHALL be 0.
REQ-038 The opcode SHALL be captured in an internal register in DECODE, so the I_EXEC, MEM_ADDR and BRANCH decisions are immune to IR changes.
REQ-039 Latency in cycles (FETCH to next FETCH exclusive): R 4, lw 5, sw 4, I-type 4, beq/bne 3, j 3, illegal 2.

Reset
REQ-040 While reset=1, all outputs SHALL be 0 and the state SHALL load FETCH on the clock edge.
REQ-041 Reset asserted in any state, including mid-instruction, SHALL abort the instruction with no further write strobes.
REQ-042 The first cycle after reset deasserts SHALL be FETCH.

Structure
REQ-043 The opcode constants, the state encoding (4 bits) and the alu_op codes SHALL live in a shared package, reused by the ALU control stage.
REQ-044 The block SHALL be a single module with no sub-modules, split into a next-state process and an output-decode process.

Verification
REQ-045 reset=1 for 2 cycles, then release -> all outputs 0 during reset; cycle 1 after release shows ir_write=1, mem_read=1, pc_en=1.
REQ-046 opcode=000000 -> states FETCH, DECODE, R_EXEC (alu_op=0010), R_WB (reg_write=1, reg_dst=1), then FETCH.
REQ-047 opcode=100011 -> 5 cycles; MEM_WB has mem_to_reg=1, reg_write=1. opcode=101011 -> 4 cycles with mem_write=1 only in MEM_WR.
REQ-048 beq with zero=1 -> pc_en=1 in BRANCH. beq with zero=0 -> pc_en=0. bne inverts both results.
REQ-049 opcode=001101 -> I_EXEC has alu_op=0101 and ext_zero=1. opcode=111111 -> illegal=1 exactly one cycle, no reg_write or mem_write, back to FETCH.
REQ-050 reset=1 asserted during MEM_WR and during R_WB -> next cycle all outputs 0; after release, restarts at FETCH.

Source files
------------

// File: rtl/main_control_pkg.sv
// Shared decode constants for the multicycle controller and the ALU control stage.
// Latency: n/a (constants, types and one pure decode function).
// Backpressure: n/a.
package main_control_pkg;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Operation class handed to the ALU control stage
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_LUI   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    // Datapath control word; field order mirrors the top-level output list
    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // State that follows DECODE for a given opcode; ST_FETCH means undefined opcode
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                                 return ST_R_EXEC;
            OP_LW, OP_SW:                             return ST_MEM_ADDR;
            OP_BEQ, OP_BNE:                           return ST_BRANCH;
            OP_J:                                     return ST_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: return ST_I_EXEC;
            default:                                  return ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/main_control.sv
// Multicycle MIPS-style main controller: Moore FSM driving datapath strobes and muxes.
// Latency: R/sw/I 4, lw 5, beq/bne/j 3, undefined opcode 2 cycles (FETCH to FETCH).
// Backpressure: none; advances every clock, synchronous reset aborts any instruction.
//
// Ports: clock/reset (sync, active-high); opcode = IR[31:26]; zero = ALU zero flag
// (used only in BRANCH); outputs are the datapath control strobes/selects, alu_op
// class for ALU control, and illegal (one-cycle pulse after an undefined opcode).
module main_control
    import main_control_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic       illegal
);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;
    logic       illegal_q;
    ctrl_t      ctrl;

    // op_q holds the opcode seen in DECODE so later states ignore IR changes.
    // illegal_q is set for exactly the cycle after a DECODE of an undefined
    // opcode, keeping the pulse registered rather than decoded from live IR.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_q <= (state == ST_DECODE) && (dispatch(opcode) == ST_FETCH);
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state process
    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_FETCH:    state_nxt = ST_DECODE;
            ST_DECODE:   state_nxt = dispatch(opcode);
            ST_MEM_ADDR: state_nxt = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_nxt = ST_MEM_WB;
            ST_R_EXEC:   state_nxt = ST_R_WB;
            ST_I_EXEC:   state_nxt = ST_I_WB;
            default:     state_nxt = ST_FETCH;
        endcase
    end

    // Output-decode process; only BRANCH looks at a live input (zero)
    always_comb begin
        ctrl         = '0;
        ctrl.illegal = illegal_q;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.pc_en     = 1'b1;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = 2'b11;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                case (op_q)
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    OP_LUI:  ctrl.alu_op = ALU_LUI;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
                ctrl.ext_zero = (op_q == OP_ANDI) || (op_q == OP_ORI) || (op_q == OP_LUI);
            end
            ST_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = 2'b01;
                ctrl.pc_en     = (op_q == OP_BNE) ? ~zero : zero;
            end
            ST_JUMP: begin
                ctrl.pc_source = 2'b10;
                ctrl.pc_en     = 1'b1;
            end
            default: ;
        endcase
        // Reset forces every strobe low immediately so an aborted instruction
        // cannot issue a write in the cycle reset is applied.
        if (reset) begin
            ctrl = '0;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign ext_zero   = ctrl.ext_zero;
    assign pc_source  = ctrl.pc_source;
    assign alu_op     = ctrl.alu_op;
    assign illegal    = ctrl.illegal;

endmodule
